mux64_scan_capture: RTL and testbench

//  Upstream and downstream companion of the 64:1 bit mux (mux64x1). Drives the 6-bit select over channels 0..63.

---
 rtl/mux_scan_pkg.sv | 22 ++
 rtl/mux64x1.sv | 16 +
 rtl/mux_scan_settle_cnt.sv | 46 ++++
 rtl/mux64_scan_capture.sv | 140 ++++++++++++++
 tb/tb_mux64_scan_capture.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/mux_scan_pkg.sv
// ---------------------------------------------------------------------------
// mux_scan_pkg
// Shared types and constants for the 64:1 mux scan-capture block.
//   scan_state_e : FSM states of the scanner
//   SEL_W_DEF    : default select width (64 channels)
//   SETTLE_MAX   : largest settle time the 4-bit settle counter can express
//   CH_N         : default channel count
// ---------------------------------------------------------------------------
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    HOLD   = 2'd3
  } scan_state_e;

  localparam int SEL_W_DEF  = 6;
  localparam int SETTLE_MAX = 15;
  localparam int CH_N       = 64;

endpackage : mux_scan_pkg

// File: rtl/mux64x1.sv
// ---------------------------------------------------------------------------
// mux64x1
// Plain 64:1 single-bit combinational multiplexer scanned by mux64_scan_capture.
//   in_i  [63:0] : candidate bits
//   sel_i [5:0]  : channel select
//   out_o        : in_i[sel_i]
// ---------------------------------------------------------------------------
module mux64x1 (
  input  logic [63:0] in_i,
  input  logic [5:0]  sel_i,
  output logic        out_o
);

  assign out_o = in_i[sel_i];

endmodule : mux64x1

// File: rtl/mux_scan_settle_cnt.sv
// ---------------------------------------------------------------------------
// mux_scan_settle_cnt
// 4-bit settle-time counter for the scanner.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   clear_i : force count to 0 (has priority over en_i)
//   en_i    : increment count
//   done_o  : count has reached SETTLE_CYCLES-1, i.e. the current cycle is
//             the last settle cycle of the channel
// SETTLE_CYCLES must lie in 1..SETTLE_MAX.
// ---------------------------------------------------------------------------
module mux_scan_settle_cnt
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic done_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == 4'(SETTLE_CYCLES - 1));

endmodule : mux_scan_settle_cnt

// File: rtl/mux64_scan_capture.sv
// ---------------------------------------------------------------------------
// mux64_scan_capture
// Steps a 64:1 bit mux through every channel, waits SETTLE_CYCLES per channel,
// samples the mux output and publishes the assembled 64-bit word on a
// valid/ready handshake. A scan is launched by a one-cycle start pulse.
//   clk           : clock, rising edge
//   rst_n         : asynchronous active-low reset (aborts any scan)
//   start_i       : scan request, only honoured in IDLE
//   busy_o        : scan in progress or word awaiting acceptance
//   sel_o         : channel select to the mux
//   mux_out_i     : mux output bit
//   word_o        : captured word, bit i sampled while sel_o == i
//   word_valid_o  : word available, held until accepted
//   word_ready_i  : consumer accepts when word_valid_o && word_ready_i
//   word_parity_o : XOR of word_o, only when MUX_SCAN_PARITY_EN is defined
// Optional feature macro: MUX_SCAN_PARITY_EN.
// ---------------------------------------------------------------------------
module mux64_scan_capture
  import mux_scan_pkg::*;
#(
  parameter int SEL_W         = SEL_W_DEF,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  output logic                    busy_o,
  output logic [SEL_W-1:0]        sel_o,
  input  logic                    mux_out_i,
  output logic [(2**SEL_W)-1:0]   word_o,
  output logic                    word_valid_o,
  input  logic                    word_ready_i
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic                    word_parity_o
`endif
);

  localparam int CH = 2 ** SEL_W;
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(CH - 1);

  scan_state_e      state_q;
  logic [SEL_W-1:0] sel_q;
  logic             busy_q;
  logic [CH-1:0]    cap_q;
  logic [CH-1:0]    word_q;
  logic             word_valid_q;
  logic [CH-1:0]    word_d;
  logic             settle_done;
`ifdef MUX_SCAN_PARITY_EN
  logic             word_parity_q;
`endif

  // Counter runs only while settling and restarts from zero on every entry
  // into SETTLE, since every other state holds it cleared.
  mux_scan_settle_cnt #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear_i(state_q != SETTLE),
    .en_i   (state_q == SETTLE),
    .done_o (settle_done)
  );

  // The last channel's sample is still in flight when the word is published,
  // so it is merged straight from the mux rather than from cap_q.
  for (genvar gi = 0; gi < CH; gi++) begin : g_word_merge
    if (gi == CH - 1) begin : g_last
      assign word_d[gi] = mux_out_i;
    end else begin : g_rest
      assign word_d[gi] = cap_q[gi];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      sel_q         <= '0;
      busy_q        <= 1'b0;
      cap_q         <= '0;
      word_q        <= '0;
      word_valid_q  <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
      word_parity_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= SETTLE;
            sel_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        SETTLE: begin
          if (settle_done) begin
            state_q <= SAMPLE;
          end
        end
        SAMPLE: begin
          cap_q[sel_q] <= mux_out_i;
          if (sel_q == SEL_LAST) begin
            state_q       <= HOLD;
            word_q        <= word_d;
            word_valid_q  <= 1'b1;
`ifdef MUX_SCAN_PARITY_EN
            word_parity_q <= ^word_d;
`endif
          end else begin
            state_q <= SETTLE;
            sel_q   <= sel_q + SEL_W'(1);
          end
        end
        HOLD: begin
          // A start coinciding with the accept is dropped: IDLE is entered
          // only after this edge, and start is looked at only in IDLE.
          if (word_ready_i) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            word_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign sel_o         = sel_q;
  assign word_o        = word_q;
  assign word_valid_o  = word_valid_q;
`ifdef MUX_SCAN_PARITY_EN
  assign word_parity_o = word_parity_q;
`endif

endmodule : mux64_scan_capture

// File: tb/tb_mux64_scan_capture.sv
module tb_mux64_scan_capture;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Procedurally driven inputs (index 0: SETTLE_CYCLES=2, index 1: =1)
  logic        start_s [2];
  logic        ready_s [2];
  logic [63:0] in_s    [2];
  // DUT-driven outputs
  logic        busy_s  [2];
  logic [5:0]  sel_s   [2];
  logic        mux_s   [2];
  logic [63:0] word_s  [2];
  logic        valid_s [2];
`ifdef MUX_SCAN_PARITY_EN
  logic        par_s   [2];
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mux64x1 u_mux0 (.in_i(in_s[0]), .sel_i(sel_s[0]), .out_o(mux_s[0]));
  mux64x1 u_mux1 (.in_i(in_s[1]), .sel_i(sel_s[1]), .out_o(mux_s[1]));

  mux64_scan_capture #(.SEL_W(6), .SETTLE_CYCLES(2)) u_dut0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_s[0]),
    .busy_o       (busy_s[0]),
    .sel_o        (sel_s[0]),
    .mux_out_i    (mux_s[0]),
    .word_o       (word_s[0]),
    .word_valid_o (valid_s[0]),
    .word_ready_i (ready_s[0])
`ifdef MUX_SCAN_PARITY_EN
    ,
    .word_parity_o(par_s[0])
`endif
  );

  mux64_scan_capture #(.SEL_W(6), .SETTLE_CYCLES(1)) u_dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_s[1]),
    .busy_o       (busy_s[1]),
    .sel_o        (sel_s[1]),
    .mux_out_i    (mux_s[1]),
    .word_o       (word_s[1]),
    .word_valid_o (valid_s[1]),
    .word_ready_i (ready_s[1])
`ifdef MUX_SCAN_PARITY_EN
    ,
    .word_parity_o(par_s[1])
`endif
  );

  typedef struct {
    int          dut;
    int          settle;
    logic [63:0] in_word;
    logic [63:0] exp_word;
    int          exp_lat;
    logic        exp_par;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch a scan and follow it until word_valid rises. lat counts edges after
  // the edge that accepted start. sel_ok: channels visited 0..63 in order, each
  // held settle+1 cycles. busy_ok: busy high on every cycle of the scan.
  task automatic run_scan(input int d, input int settle, input bit inject,
                          output int lat, output bit sel_ok, output bit busy_ok);
    int prev;
    int run;
    start_s[d] = 1'b1;
    tick();
    start_s[d] = 1'b0;
    lat = 0; prev = 0; run = 0; sel_ok = 1'b1; busy_ok = 1'b1;
    while (lat < 1000) begin
      if (valid_s[d]) break;
      if (!busy_s[d]) busy_ok = 1'b0;
      if (int'(sel_s[d]) != prev) begin
        if (run != settle + 1 || int'(sel_s[d]) != prev + 1) sel_ok = 1'b0;
        prev = int'(sel_s[d]);
        run  = 1;
      end else begin
        run++;
      end
      start_s[d] = inject && (lat == 5 || lat == 50 || lat == 100);
      tick();
      lat++;
    end
    start_s[d] = 1'b0;
    if (prev != 63 || run != settle + 1) sel_ok = 1'b0;
    $display("scan dut%0d in=%h word=%h latency=%0d", d, in_s[d], word_s[d], lat);
  endtask

  initial begin
    int  lat;
    bit  sel_ok;
    bit  busy_ok;
    bit  ok;
    logic [63:0] held;

    vecs[0] = '{0, 2, 64'h0123_4567_89ab_cdef, 64'h0123_4567_89ab_cdef, 192, 1'b0};
    vecs[1] = '{0, 2, 64'hFFFF_0000_AAAA_5555, 64'hFFFF_0000_AAAA_5555, 192, 1'b0};
    vecs[2] = '{0, 2, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 192, 1'b0};
    vecs[3] = '{0, 2, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 192, 1'b0};
    vecs[4] = '{0, 2, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001, 192, 1'b1};
    vecs[5] = '{0, 2, 64'h0000_0000_0000_0003, 64'h0000_0000_0000_0003, 192, 1'b0};
    vecs[6] = '{1, 1, 64'h0123_4567_89ab_cdef, 64'h0123_4567_89ab_cdef, 128, 1'b0};
    vecs[7] = '{1, 1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 128, 1'b1};

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0;
      ready_s[d] = 1'b1;
      in_s[d]    = '0;
    end
    repeat (3) tick();

    // Reset state
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_busy%0d", d),  64'(busy_s[d]),  64'd0);
      chk($sformatf("rst_sel%0d", d),   64'(sel_s[d]),   64'd0);
      chk($sformatf("rst_valid%0d", d), 64'(valid_s[d]), 64'd0);
      chk($sformatf("rst_word%0d", d),  word_s[d],       64'd0);
`ifdef MUX_SCAN_PARITY_EN
      chk($sformatf("rst_par%0d", d),   64'(par_s[d]),   64'd0);
`endif
    end
    rst_n = 1'b1;
    tick();

    // Table-driven scans, consumer always ready
    for (int i = 0; i < 8; i++) begin
      int d;
      d = vecs[i].dut;
      in_s[d]    = vecs[i].in_word;
      ready_s[d] = 1'b1;
      run_scan(d, vecs[i].settle, 1'b0, lat, sel_ok, busy_ok);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      chk($sformatf("v%0d_sel_seq", i), 64'(sel_ok), 64'd1);
      chk($sformatf("v%0d_busy", i), 64'(busy_ok), 64'd1);
      chk($sformatf("v%0d_word", i), word_s[d], vecs[i].exp_word);
`ifdef MUX_SCAN_PARITY_EN
      chk($sformatf("v%0d_parity", i), 64'(par_s[d]), 64'(vecs[i].exp_par));
`endif
      tick();
      chk($sformatf("v%0d_valid_drop", i), 64'(valid_s[d]), 64'd0);
      chk($sformatf("v%0d_idle", i), 64'(busy_s[d]), 64'd0);
      chk($sformatf("v%0d_word_kept", i), word_s[d], vecs[i].exp_word);
    end

    // Back-pressure: word held for 20 cycles, drops one cycle after ready
    in_s[0]    = 64'h0123_4567_89ab_cdef;
    ready_s[0] = 1'b0;
    run_scan(0, 2, 1'b0, lat, sel_ok, busy_ok);
    chk("bp_latency", 64'(lat), 64'd192);
    held = word_s[0];
    ok   = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (!valid_s[0] || !busy_s[0] || word_s[0] !== held || sel_s[0] != 6'd63) ok = 1'b0;
    end
    chk("bp_hold_stable", 64'(ok), 64'd1);
    chk("bp_word", word_s[0], 64'h0123_4567_89ab_cdef);
    ready_s[0] = 1'b1;
    tick();
    chk("bp_valid_drop", 64'(valid_s[0]), 64'd0);
    $display("backpressure hold 20 cycles word=%h", held);

    // Start pulses during a running scan and at the accept are ignored
    in_s[0] = 64'hFFFF_0000_AAAA_5555;
    run_scan(0, 2, 1'b1, lat, sel_ok, busy_ok);
    chk("ign_latency", 64'(lat), 64'd192);
    chk("ign_sel_seq", 64'(sel_ok), 64'd1);
    chk("ign_busy", 64'(busy_ok), 64'd1);
    chk("ign_word", word_s[0], 64'hFFFF_0000_AAAA_5555);
    start_s[0] = 1'b1;   // coincides with the accept edge
    tick();
    start_s[0] = 1'b0;
    chk("ign_accept_start_busy", 64'(busy_s[0]), 64'd0);
    ok = 1'b1;
    for (int c = 0; c < 250; c++) begin
      tick();
      if (busy_s[0] || valid_s[0]) ok = 1'b0;
    end
    chk("ign_single_word", 64'(ok), 64'd1);
    $display("ignored-start scan word=%h", word_s[0]);

    // Reset mid-scan
    in_s[0]    = 64'h0123_4567_89ab_cdef;
    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    repeat (89) tick();
    chk("mid_busy_before_rst", 64'(busy_s[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy_s[0]), 64'd0);
    chk("mid_rst_sel", 64'(sel_s[0]), 64'd0);
    chk("mid_rst_valid", 64'(valid_s[0]), 64'd0);
    chk("mid_rst_word", word_s[0], 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    in_s[0] = 64'hFFFF_0000_AAAA_5555;
    run_scan(0, 2, 1'b0, lat, sel_ok, busy_ok);
    chk("post_rst_latency", 64'(lat), 64'd192);
    chk("post_rst_word", word_s[0], 64'hFFFF_0000_AAAA_5555);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mux64_scan_capture
